// File: rtl/s_axi_reg_pkg.sv
// Shared types and helpers for the AXI3 burst register file.
// Burst encodings, response codes, FSM state enums and burst legality checks.
package s_axi_reg_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        case (len)
            4'd1, 4'd3, 4'd7, 4'd15: wrap_len_ok = 1'b1;
            default:                 wrap_len_ok = 1'b0;
        endcase
    endfunction

    // A burst that can never be serviced: reserved type or a WRAP with a non power-of-two beat count
    function automatic logic burst_bad(input burst_t burst, input logic [3:0] len);
        case (burst)
            FIXED:   burst_bad = 1'b0;
            INCR:    burst_bad = 1'b0;
            WRAP:    burst_bad = !wrap_len_ok(len);
            default: burst_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-word-index calculator for FIXED / INCR / WRAP bursts.
module axi_burst_addr
    import s_axi_reg_pkg::*;
#(
    parameter int IDX_W = 30
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       len,
    input  burst_t           burst,
    output logic [IDX_W-1:0] next_idx
);

    logic [IDX_W-1:0] mask_s;
    logic [IDX_W-1:0] inc_s;

    assign mask_s = IDX_W'(len);
    assign inc_s  = idx + IDX_W'(1);

    // WRAP keeps the upper bits and lets the low len bits roll over inside the window
    always_comb begin
        case (burst)
            FIXED:   next_idx = idx;
            INCR:    next_idx = inc_s;
            WRAP:    next_idx = (idx & ~mask_s) | (inc_s & mask_s);
            default: next_idx = idx;
        endcase
    end

endmodule

// File: rtl/s_axi_reg_burst.sv
// AXI3 slave register file with FIXED/INCR/WRAP bursts, ID echo and a read-only
// XOR checksum word located directly above the register array.
module s_axi_reg_burst
    import s_axi_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_COUNT  = 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [3:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [3:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int REG_W    = $clog2(REG_COUNT);
    localparam logic [2:0]       BEAT_SIZE = 3'(ADDR_LSB);
    localparam logic [IDX_W-1:0] CSUM_IDX  = IDX_W'(REG_COUNT);

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
    logic [DATA_WIDTH-1:0] checksum_s;

    wr_state_t             w_state_r;
    logic [IDX_W-1:0]      w_idx_r;
    logic [3:0]            w_len_r;
    logic [3:0]            w_cnt_r;
    burst_t                w_burst_r;
    logic                  w_nowr_r;
    logic                  w_err_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [ID_WIDTH-1:0]   bid_r;
    logic [1:0]            bresp_r;

    rd_state_t             r_state_r;
    logic [IDX_W-1:0]      r_idx_r;
    logic [3:0]            r_len_r;
    logic [3:0]            r_cnt_r;
    burst_t                r_burst_r;
    logic                  r_bad_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [ID_WIDTH-1:0]   rid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;

    logic [IDX_W-1:0]      aw_idx_s;
    logic                  aw_bad_s;
    logic                  w_last_s;
    logic                  w_hit_s;
    logic                  w_beat_err_s;
    logic                  w_hs_s;
    logic                  wr_en_s;
    logic [IDX_W-1:0]      w_next_s;

    logic [IDX_W-1:0]      ar_idx_s;
    logic                  ar_bad_s;
    logic [IDX_W-1:0]      rd_cur_idx_s;
    logic [3:0]            rd_len_s;
    burst_t                rd_burst_s;
    logic                  rd_bad_s;
    logic [IDX_W-1:0]      rd_next_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [1:0]            rd_resp_s;

    logic                  unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^{awaddr_i[ADDR_LSB-1:0], araddr_i[ADDR_LSB-1:0]};

    assign awready_o = awready_r;
    assign wready_o  = wready_r;
    assign bvalid_o  = bvalid_r;
    assign bid_o     = bid_r;
    assign bresp_o   = bresp_r;
    assign arready_o = arready_r;
    assign rvalid_o  = rvalid_r;
    assign rlast_o   = rlast_r;
    assign rid_o     = rid_r;
    assign rdata_o   = rdata_r;
    assign rresp_o   = rresp_r;

    // Checksum over the current register contents
    always_comb begin
        checksum_s = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            checksum_s = checksum_s ^ regs_r[i];
        end
    end

    assign aw_idx_s     = awaddr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign aw_bad_s     = burst_bad(burst_t'(awburst_i), awlen_i) || (awsize_i != BEAT_SIZE);
    assign w_last_s     = (w_cnt_r == w_len_r);
    assign w_hit_s      = (w_idx_r < CSUM_IDX);
    assign w_beat_err_s = !w_hit_s || (wlast_i != w_last_s);
    assign w_hs_s       = (w_state_r == W_DATA) && wvalid_i && wready_r;
    assign wr_en_s      = w_hs_s && !w_nowr_r && w_hit_s;

    axi_burst_addr #(.IDX_W(IDX_W)) u_wr_addr (
        .idx      (w_idx_r),
        .len      (w_len_r),
        .burst    (w_burst_r),
        .next_idx (w_next_s)
    );

    // Register array: cleared on reset, byte-merged on accepted in-range write beats
    always_ff @(posedge clk) begin
        if (!areset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    regs_r[w_idx_r[REG_W-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Write channel FSM: one AW, its W beats, then a single B response
    always_ff @(posedge clk) begin
        if (!areset) begin
            w_state_r <= W_IDLE;
            w_idx_r   <= '0;
            w_len_r   <= 4'd0;
            w_cnt_r   <= 4'd0;
            w_burst_r <= FIXED;
            w_nowr_r  <= 1'b0;
            w_err_r   <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awvalid_i && awready_r) begin
                        bid_r     <= awid_i;
                        w_idx_r   <= aw_idx_s;
                        w_len_r   <= awlen_i;
                        w_burst_r <= burst_t'(awburst_i);
                        w_cnt_r   <= 4'd0;
                        w_nowr_r  <= aw_bad_s;
                        w_err_r   <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        w_err_r <= w_err_r | w_beat_err_s;
                        if (w_last_s) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= (w_nowr_r || w_err_r || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end else begin
                            w_cnt_r <= w_cnt_r + 4'd1;
                            w_idx_r <= w_next_s;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ar_idx_s = araddr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_bad_s = burst_bad(burst_t'(arburst_i), arlen_i) || (arsize_i != BEAT_SIZE);

    // In R_IDLE the beat being prepared comes straight from the AR channel
    always_comb begin
        if (r_state_r == R_IDLE) begin
            rd_cur_idx_s = ar_idx_s;
            rd_len_s     = arlen_i;
            rd_burst_s   = burst_t'(arburst_i);
            rd_bad_s     = ar_bad_s;
        end else begin
            rd_cur_idx_s = r_idx_r;
            rd_len_s     = r_len_r;
            rd_burst_s   = r_burst_r;
            rd_bad_s     = r_bad_r;
        end
    end

    axi_burst_addr #(.IDX_W(IDX_W)) u_rd_addr (
        .idx      (rd_cur_idx_s),
        .len      (rd_len_s),
        .burst    (rd_burst_s),
        .next_idx (rd_next_s)
    );

    // Data and response for the beat about to be loaded
    always_comb begin
        rd_data_s = '0;
        rd_resp_s = RESP_SLVERR;
        if (rd_bad_s) begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end else if (rd_cur_idx_s < CSUM_IDX) begin
            rd_data_s = regs_r[rd_cur_idx_s[REG_W-1:0]];
            rd_resp_s = RESP_OKAY;
        end else if (rd_cur_idx_s == CSUM_IDX) begin
            rd_data_s = checksum_s;
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Read channel FSM: r_idx_r always points at the beat that follows the one on the bus
    always_ff @(posedge clk) begin
        if (!areset) begin
            r_state_r <= R_IDLE;
            r_idx_r   <= '0;
            r_len_r   <= 4'd0;
            r_cnt_r   <= 4'd0;
            r_burst_r <= FIXED;
            r_bad_r   <= 1'b0;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arvalid_i && arready_r) begin
                        rid_r     <= arid_i;
                        r_len_r   <= arlen_i;
                        r_burst_r <= burst_t'(arburst_i);
                        r_bad_r   <= ar_bad_s;
                        r_cnt_r   <= 4'd0;
                        r_idx_r   <= rd_next_s;
                        rdata_r   <= rd_data_s;
                        rresp_r   <= rd_resp_s;
                        rlast_r   <= (arlen_i == 4'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            r_cnt_r <= r_cnt_r + 4'd1;
                            r_idx_r <= rd_next_s;
                            rdata_r <= rd_data_s;
                            rresp_r <= rd_resp_s;
                            rlast_r <= ((r_cnt_r + 4'd1) == r_len_r);
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_axi_reg_burst.sv
// Directed plus randomized bench for s_axi_reg_burst against an array-based reference model.
module tb_s_axi_reg_burst;

    localparam int NREG = 8;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awid_i, arid_i;
    logic [31:0] awaddr_i, araddr_i;
    logic [3:0]  awlen_i, arlen_i;
    logic [2:0]  awsize_i, arsize_i;
    logic [1:0]  awburst_i, arburst_i;
    logic        awvalid_i, arvalid_i;
    logic        awready_o, arready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i, wvalid_i, wready_o;
    logic [3:0]  bid_o, rid_o;
    logic [1:0]  bresp_o, rresp_o;
    logic        bvalid_o, bready_i;
    logic [31:0] rdata_o;
    logic        rlast_o, rvalid_o, rready_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [NREG];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    s_axi_reg_burst dut (
        .clk(clk), .areset(areset),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
        .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_bad(input logic [1:0] burst, input logic [3:0] len, input logic [2:0] size);
        return (burst == 2'd3) || (burst == 2'd2 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) || (size != 3'd2);
    endfunction

    // Word index of beat k, from the burst rules expressed arithmetically
    function automatic int unsigned seq_idx(input int unsigned start, input int unsigned len,
                                            input logic [1:0] burst, input int unsigned k);
        int unsigned w;
        int unsigned base;
        w = len + 1;
        case (burst)
            2'd1:    return start + k;
            2'd2: begin
                base = (start / w) * w;
                return base + ((start - base + k) % w);
            end
            default: return start;
        endcase
    endfunction

    function automatic logic [31:0] model_csum();
        logic [31:0] x = 32'd0;
        for (int i = 0; i < NREG; i++) x ^= m_regs[i];
        return x;
    endfunction

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit flip_last);
        int unsigned start;
        int unsigned idx;
        bit bad;
        bit err;
        int cyc;
        start = addr >> 2;
        bad = is_bad(burst, len, size);
        err = 1'b0;
        awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awsize_i = size;
        awvalid_i = 1'b1;
        cyc = 0;
        while (!awready_o && cyc < 50) begin tick(); cyc++; end
        chk("aw_ready", awready_o, 1);
        tick();
        awvalid_i = 1'b0;
        chk("aw_ready_drop", awready_o, 0);
        chk("w_ready_rise", wready_o, 1);
        for (int k = 0; k <= int'(len); k++) begin
            idx = seq_idx(start, len, burst, k);
            wdata_i = wd[k]; wstrb_i = ws[k];
            wlast_i = (k == int'(len)) ^ (flip_last && k == int'(len));
            wvalid_i = 1'b1;
            cyc = 0;
            while (!wready_o && cyc < 50) begin tick(); cyc++; end
            chk("w_ready", wready_o, 1);
            tick();
            if (!bad) begin
                if (idx < NREG) begin
                    for (int b = 0; b < 4; b++)
                        if (ws[k][b]) m_regs[idx][8*b +: 8] = wd[k][8*b +: 8];
                end else begin
                    err = 1'b1;
                end
            end
            if (flip_last && k == int'(len)) err = 1'b1;
        end
        wvalid_i = 1'b0; wlast_i = 1'b0;
        bready_i = 1'b1;
        cyc = 0;
        while (!bvalid_o && cyc < 50) begin tick(); cyc++; end
        chk("b_valid", bvalid_o, 1);
        chk("b_id", bid_o, id);
        chk("b_resp", bresp_o, (bad || err) ? 2'b10 : 2'b00);
        tick();
        bready_i = 1'b0;
        chk("b_done_valid", bvalid_o, 0);
        chk("b_done_awready", awready_o, 1);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit toggle);
        int unsigned start;
        int unsigned idx;
        bit bad;
        int k;
        int cyc;
        bit hold_v;
        logic [31:0] hold_d;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        start = addr >> 2;
        bad = is_bad(burst, len, size);
        arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arsize_i = size;
        arvalid_i = 1'b1;
        cyc = 0;
        while (!arready_o && cyc < 50) begin tick(); cyc++; end
        chk("ar_ready", arready_o, 1);
        tick();
        arvalid_i = 1'b0;
        chk("ar_ready_drop", arready_o, 0);
        k = 0; cyc = 0; hold_v = 1'b0; hold_d = 32'd0;
        while (k <= int'(len) && cyc < 200) begin
            rready_i = toggle ? cyc[0] : 1'b1;
            if (rvalid_o && rready_i) begin
                idx = seq_idx(start, len, burst, k);
                if (bad)               begin exp_d = 32'd0;        exp_r = 2'b10; end
                else if (idx < NREG)   begin exp_d = m_regs[idx];  exp_r = 2'b00; end
                else if (idx == NREG)  begin exp_d = model_csum(); exp_r = 2'b00; end
                else                   begin exp_d = 32'd0;        exp_r = 2'b10; end
                chk("r_data", rdata_o, exp_d);
                chk("r_resp", rresp_o, exp_r);
                chk("r_id", rid_o, id);
                chk("r_last", rlast_o, k == int'(len));
                k++;
            end else if (rvalid_o) begin
                hold_v = 1'b1;
                hold_d = rdata_o;
            end
            tick();
            cyc++;
            if (hold_v) begin
                chk("r_hold_valid", rvalid_o, 1);
                chk("r_hold_data", rdata_o, hold_d);
                hold_v = 1'b0;
            end
        end
        rready_i = 1'b0;
        chk("r_beats", k, int'(len) + 1);
        chk("r_done_valid", rvalid_o, 0);
        chk("r_done_arready", arready_o, 1);
    endtask

    initial begin
        logic [1:0] rb;
        logic [2:0] rs;
        int unsigned ri;
        logic [3:0] rl;

        areset = 1'b0;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = 3'd2; awburst_i = 2'd1; awvalid_i = 1'b0;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = 3'd2; arburst_i = 2'd1; arvalid_i = 1'b0;
        wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
        bready_i = 1'b0; rready_i = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
        repeat (3) tick();

        chk("rst_awready", awready_o, 1);
        chk("rst_arready", arready_o, 1);
        chk("rst_wready", wready_o, 0);
        chk("rst_bvalid", bvalid_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_outs", {bid_o, rid_o, bresp_o, rresp_o, rdata_o, rlast_o}, 0);
        areset = 1'b1;
        tick();

        // Single write then read back
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr_burst(4'd3, 32'h08, 4'd0, 2'd1, 3'd2, 1'b0);
        rd_burst(4'd3, 32'h08, 4'd0, 2'd1, 3'd2, 1'b0);

        // INCR 4-beat write, stalled 4-beat read
        for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
        wr_burst(4'd1, 32'h04, 4'd3, 2'd1, 3'd2, 1'b0);
        rd_burst(4'd2, 32'h04, 4'd3, 2'd1, 3'd2, 1'b1);

        // WRAP reads: legal len 3 and illegal len 2
        rd_burst(4'd4, 32'h08, 4'd3, 2'd2, 3'd2, 1'b0);
        rd_burst(4'd5, 32'h08, 4'd2, 2'd2, 3'd2, 1'b0);

        // Burst running off the array end, then checksum and out-of-range reads
        wd[0] = 32'hCAFE0007; wd[1] = 32'h12345678; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_burst(4'd6, 32'h1C, 4'd1, 2'd1, 3'd2, 1'b0);
        rd_burst(4'd7, 32'h20, 4'd0, 2'd1, 3'd2, 1'b0);
        rd_burst(4'd8, 32'h24, 4'd0, 2'd1, 3'd2, 1'b0);

        // Byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wr_burst(4'd9, 32'h00, 4'd0, 2'd0, 3'd2, 1'b0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        wr_burst(4'd9, 32'h00, 4'd0, 2'd0, 3'd2, 1'b0);
        rd_burst(4'd9, 32'h00, 4'd0, 2'd0, 3'd2, 1'b0);

        // wlast mismatch and unsupported size
        wd[0] = 32'h0000_5A5A; wd[1] = 32'h0000_A5A5; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_burst(4'd10, 32'h14, 4'd1, 2'd1, 3'd2, 1'b1);
        wr_burst(4'd11, 32'h14, 4'd1, 2'd1, 3'd1, 1'b0);
        rd_burst(4'd11, 32'h10, 4'd3, 2'd1, 3'd1, 1'b0);

        // Randomized bursts
        for (int it = 0; it < 30; it++) begin
            ri = $urandom_range(0, 10);
            rl = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2: rb = 2'd0;
                3, 4, 5: rb = 2'd1;
                6, 7, 8: rb = 2'd2;
                default: rb = 2'd3;
            endcase
            rs = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                wr_burst(4'($urandom), (ri << 2) | 32'($urandom_range(0, 3)), rl, rb, rs, 1'b0);
            end else begin
                rd_burst(4'($urandom), (ri << 2) | 32'($urandom_range(0, 3)), rl, rb, rs, $urandom_range(0, 1) == 1);
            end
        end
        rd_burst(4'd12, 32'h00, 4'd8, 2'd1, 3'd2, 1'b0);

        // Reset in the middle of a 4-beat write
        awid_i = 4'd5; awaddr_i = 32'h0; awlen_i = 4'd3; awburst_i = 2'd1; awsize_i = 3'd2;
        awvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wdata_i = 32'hF00D0000 + k; wstrb_i = 4'hF; wlast_i = 1'b0; wvalid_i = 1'b1;
            tick();
        end
        wvalid_i = 1'b0;
        areset = 1'b0;
        tick();
        chk("mid_rst_awready", awready_o, 1);
        chk("mid_rst_arready", arready_o, 1);
        chk("mid_rst_wready", wready_o, 0);
        chk("mid_rst_outs", {bvalid_o, rvalid_o, bid_o, bresp_o}, 0);
        areset = 1'b1;
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
        bready_i = 1'b1;
        repeat (3) begin
            tick();
            chk("mid_rst_no_b", bvalid_o, 0);
        end
        bready_i = 1'b0;
        rd_burst(4'd13, 32'h00, 4'd8, 2'd1, 3'd2, 1'b0);
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        wr_burst(4'd14, 32'h0C, 4'd0, 2'd1, 3'd2, 1'b0);
        rd_burst(4'd14, 32'h0C, 4'd0, 2'd1, 3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
